// File: rtl/hk_frame_builder_if.sv
// hk_frame_builder_if -- byte stream from the housekeeping framer toward the
// telemetry UART/packet mux.
//
// Signals:
//   out_data   8  frame byte (driven by the framer)
//   out_valid  1  out_data holds a valid byte (driven by the framer)
//   out_ready  1  downstream accepts the current byte (driven by the sink)
//
// Modports:
//   master  framer side (drives data/valid, samples ready)
//   slave   sink side   (samples data/valid, drives ready)
interface hk_frame_builder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/hk_frame_builder.sv
// hk_frame_builder -- housekeeping telemetry framer.
//
// On frame_tick (while idle) the ten 10-bit housekeeping words are frozen in a
// snapshot and sent as a byte frame:
//   0: SYNC0   1: SYNC1   2: seq_cnt   3..22: words, big-endian per word
//   23: 8-bit modular sum of bytes 2..22 (only when HKF_CKSUM_EN is defined)
//
// Build option:
//   HKF_CKSUM_EN  defined   -> checksum byte present, frame is 24 bytes
//                 undefined -> no accumulator, frame is 23 bytes
//
// Ports:
//   clk50          in   1    system clock, rising edge
//   rst            in   1    asynchronous active-high reset
//   hk_words_flat  in   100  word k at bits [10k+9:10k]
//   frame_tick     in   1    single-cycle frame request
//   out_if         master    byte stream (out_data/out_valid/out_ready)
//   busy           out  1    a frame is in progress
//   seq_cnt        out  8    sequence number of the next frame
//   drop_cnt       out  8    saturating count of ticks ignored while busy
module hk_frame_builder #(
  parameter logic [7:0] SYNC0 = 8'hEB,
  parameter logic [7:0] SYNC1 = 8'h90
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic [99:0]         hk_words_flat,
  input  logic                frame_tick,
  hk_frame_builder_if.master  out_if,
  output logic                busy,
  output logic [7:0]          seq_cnt,
  output logic [7:0]          drop_cnt
);

`ifdef HKF_CKSUM_EN
  localparam int FLEN = 24;
`else
  localparam int FLEN = 23;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FLEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [99:0] snap_q, snap_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  data_q, data_d;
`ifdef HKF_CKSUM_EN
  logic [7:0]  cksum_q, cksum_d;
`endif

  logic       start;
  logic       xfer;
  logic [4:0] nxt_idx;
  logic [4:0] data_sel;
  logic [7:0] nxt_byte;
  logic [7:0] data_bytes [20];

  assign start    = (state_q == IDLE) && frame_tick;
  assign xfer     = (state_q == SEND) && out_if.out_ready;
  assign nxt_idx  = idx_q + 5'd1;
  assign data_sel = nxt_idx - 5'd3;

  // Snapshot words laid out as the twenty data bytes, high part first.
  for (genvar gi = 0; gi < 10; gi++) begin : g_words
    assign data_bytes[2*gi]   = {6'b0, snap_q[10*gi+8 +: 2]};
    assign data_bytes[2*gi+1] = snap_q[10*gi +: 8];
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      snap_q  <= '0;
      seq_q   <= 8'h00;
      drop_q  <= 8'h00;
      data_q  <= 8'h00;
`ifdef HKF_CKSUM_EN
      cksum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
`ifdef HKF_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_tick) state_d = SEND;
      SEND: if (xfer && (idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef HKF_CKSUM_EN
  // Accumulator is kept separate so the final byte can be taken from its
  // post-add value without a combinational loop through the data mux.
  always_comb begin
    cksum_d = cksum_q;
    if (start)
      cksum_d = 8'h00;
    else if (xfer && (idx_q >= 5'd2) && (idx_q <= 5'd22))
      cksum_d = cksum_q + data_q;
  end
`endif

  // Byte that follows the one currently presented.
  always_comb begin
    nxt_byte = 8'h00;
    if (nxt_idx == 5'd1)
      nxt_byte = SYNC1;
    else if (nxt_idx == 5'd2)
      nxt_byte = seq_q;
    else if (nxt_idx <= 5'd22)
      nxt_byte = data_bytes[data_sel];
`ifdef HKF_CKSUM_EN
    else
      nxt_byte = cksum_d;
`endif
  end

  // Datapath updates: out_data is registered and preloaded one byte ahead so
  // it only changes on an accepted transfer (held while stalled).
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    seq_d  = seq_q;
    drop_d = drop_q;
    data_d = data_q;

    if (frame_tick && (state_q != IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    if (start) begin
      snap_d = hk_words_flat;
      idx_d  = 5'd0;
      data_d = SYNC0;
    end else if (xfer) begin
      if (idx_q == LAST_IDX) begin
        seq_d  = seq_q + 8'd1;
        idx_d  = 5'd0;
        data_d = 8'h00;
      end else begin
        idx_d  = nxt_idx;
        data_d = nxt_byte;
      end
    end
  end

  // Outputs.
  always_comb begin
    out_if.out_data  = data_q;
    out_if.out_valid = (state_q == SEND);
    busy             = (state_q != IDLE);
    seq_cnt          = seq_q;
    drop_cnt         = drop_q;
  end

endmodule
